// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
// Shared pipeline definitions for the memory-access stage:
//   - access size encodings carried on size_in
//   - the FSM state type of mem_access_unit
//   - helpers for the alignment rule and the big-endian byte-lane enables
package mem_access_unit_pkg;

    // Access size encodings. The fourth code (2'b11) is treated as a word.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // A halfword must sit on an even address and a word on a multiple of
    // four; bytes can never be misaligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            default:   bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

    // Big-endian lanes: byte offset 0 lives in bits 31:24, which is be[3].
    function automatic logic [3:0] lane_enable(input logic [1:0] size,
                                               input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b1000 >> offset;
            SIZE_HALF: be = offset[1] ? 4'b0011 : 4'b1100;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align
// Picks the addressed lanes out of a big-endian memory word, moves them down
// to bit 0 and sign- or zero-extends the result to 32 bits.
// Ports:
//   rdata       - raw word returned by data memory
//   offset      - low two address bits of the access
//   size        - access size (byte / halfword / word)
//   is_unsigned - 1: zero-extend, 0: sign-extend
//   data        - aligned, extended load value
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection first, then extension according to the access size.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data     = rdata;

        case (offset)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase

        half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

        case (size)
            SIZE_BYTE: data = is_unsigned ? {24'h000000, byte_sel}
                                          : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: data = is_unsigned ? {16'h0000, half_sel}
                                          : {{16{half_sel[15]}}, half_sel};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM pipeline stage. It takes one instruction from the EX/MEM slot, runs the
// data-memory handshake for loads and stores, and hands the result to MEM/WB.
// Ports:
//   clk, reset                    - clock and asynchronous active-high reset
//   valid_in, mem_read, mem_write - instruction present / load / store
//   size_in, unsigned_in          - access size and load extension mode
//   WB_control_in, alu_result_in,
//   store_data_in, rw_in          - EX/MEM payload (alu_result_in is the address)
//   mem_req, mem_we, mem_addr,
//   mem_be, mem_wdata             - data-memory request bus
//   mem_rdata, mem_ack            - data-memory response
//   WB_control_out, data_from_mem_out,
//   data_from_ALU_out, rw_out     - payload towards MEM/WB
//   valid_out, stall_out,
//   misalign_out, bus_err_out     - completion, back-pressure and error flags
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    input  logic [1:0]  WB_control_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rw_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  WB_control_out,
    output logic [31:0] data_from_mem_out,
    output logic [31:0] data_from_ALU_out,
    output logic [4:0]  rw_out,
    output logic        valid_out,
    output logic        stall_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    state_t             state;
    logic [CNT_W-1:0]   access_cnt;
    logic [1:0]         pend_wb;
    logic [31:0]        pend_alu;
    logic [4:0]         pend_rw;
    logic [1:0]         pend_size;
    logic [1:0]         pend_offset;
    logic               pend_unsigned;
    logic               pend_load;

    logic               mem_op;
    logic               misaligned;
    logic               accept_access;
    logic               timeout_hit;
    logic [31:0]        load_data;

    // Copies the store operand onto every lane the access can select, so the
    // memory only has to honour mem_be.
    function automatic logic [31:0] replicate_store(input logic [1:0]  size,
                                                    input logic [31:0] data);
        logic [31:0] w;
        case (size)
            SIZE_BYTE: w = {4{data[7:0]}};
            SIZE_HALF: w = {2{data[15:0]}};
            default:   w = data;
        endcase
        return w;
    endfunction

    // Request decode. A store wins when both mem_read and mem_write are set.
    // The timeout fires in the ACK_TIMEOUT-th ACCESS cycle, and only when no
    // ack arrives in that same cycle.
    assign mem_op        = mem_read | mem_write;
    assign misaligned    = is_misaligned(size_in, alu_result_in[1:0]);
    assign accept_access = (state == IDLE) && valid_in && mem_op && !misaligned;
    assign timeout_hit   = (state == ACCESS) && !mem_ack &&
                           (access_cnt == CNT_W'(ACK_TIMEOUT - 1));

    // Stall is combinational so upstream holds in the accept cycle and
    // advances on the very edge that finishes the access (ack or timeout).
    assign stall_out = !reset &&
                       (accept_access || ((state == ACCESS) && !mem_ack && !timeout_hit));

    load_align u_load_align (
        .rdata       (mem_rdata),
        .offset      (pend_offset),
        .size        (pend_size),
        .is_unsigned (pend_unsigned),
        .data        (load_data)
    );

    // Main FSM. Completion flags are single-cycle pulses; payload outputs are
    // only written when an instruction completes and otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            access_cnt        <= '0;
            pend_wb           <= 2'b00;
            pend_alu          <= 32'h0;
            pend_rw           <= 5'd0;
            pend_size         <= 2'b00;
            pend_offset       <= 2'b00;
            pend_unsigned     <= 1'b0;
            pend_load         <= 1'b0;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= 32'h0;
            mem_be            <= 4'h0;
            mem_wdata         <= 32'h0;
            WB_control_out    <= 2'b00;
            data_from_mem_out <= 32'h0;
            data_from_ALU_out <= 32'h0;
            rw_out            <= 5'd0;
            valid_out         <= 1'b0;
            misalign_out      <= 1'b0;
            bus_err_out       <= 1'b0;
        end else begin
            valid_out    <= 1'b0;
            misalign_out <= 1'b0;
            bus_err_out  <= 1'b0;

            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (!mem_op) begin
                            WB_control_out    <= WB_control_in;
                            data_from_ALU_out <= alu_result_in;
                            rw_out            <= rw_in;
                            data_from_mem_out <= 32'h0;
                            valid_out         <= 1'b1;
                        end else if (misaligned) begin
                            WB_control_out    <= 2'b00;
                            data_from_ALU_out <= alu_result_in;
                            rw_out            <= rw_in;
                            data_from_mem_out <= 32'h0;
                            valid_out         <= 1'b1;
                            misalign_out      <= 1'b1;
                        end else begin
                            pend_wb       <= WB_control_in;
                            pend_alu      <= alu_result_in;
                            pend_rw       <= rw_in;
                            pend_size     <= size_in;
                            pend_offset   <= alu_result_in[1:0];
                            pend_unsigned <= unsigned_in;
                            pend_load     <= mem_read & ~mem_write;
                            mem_req       <= 1'b1;
                            mem_we        <= mem_write;
                            mem_addr      <= {alu_result_in[31:2], 2'b00};
                            mem_be        <= lane_enable(size_in, alu_result_in[1:0]);
                            mem_wdata     <= mem_write ? replicate_store(size_in, store_data_in)
                                                       : 32'h0;
                            access_cnt    <= '0;
                            state         <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    if (mem_ack) begin
                        WB_control_out    <= pend_wb;
                        data_from_ALU_out <= pend_alu;
                        rw_out            <= pend_rw;
                        data_from_mem_out <= pend_load ? load_data : 32'h0;
                        valid_out         <= 1'b1;
                        mem_req           <= 1'b0;
                        mem_we            <= 1'b0;
                        state             <= IDLE;
                    end else if (timeout_hit) begin
                        WB_control_out    <= 2'b00;
                        data_from_ALU_out <= pend_alu;
                        rw_out            <= pend_rw;
                        data_from_mem_out <= 32'h0;
                        valid_out         <= 1'b1;
                        bus_err_out       <= 1'b1;
                        mem_req           <= 1'b0;
                        mem_we            <= 1'b0;
                        state             <= IDLE;
                    end else begin
                        access_cnt <= access_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed bench for mem_access_unit. A behavioural model derives every
// completion and every memory request from the access rules using plain
// byte arithmetic; one compare process checks the DUT against it each cycle,
// and the directed sequence adds literal expectations for key cases.
module tb_mem_access_unit;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, mem_read, mem_write, unsigned_in;
    logic [1:0]  size_in, WB_control_in;
    logic [31:0] alu_result_in, store_data_in;
    logic [4:0]  rw_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [1:0]  WB_control_out;
    logic [31:0] data_from_mem_out, data_from_ALU_out;
    logic [4:0]  rw_out;
    logic        valid_out, stall_out, misalign_out, bus_err_out;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rw;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t        exp_q[$];
    logic        exp_req_on;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_we;

    int          resp_ack_at;
    logic        idle_ack;
    int          obs_lat, obs_stall, obs_req;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic        obs_we;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_access_unit #(.ACK_TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .reset             (reset),
        .valid_in          (valid_in),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .size_in           (size_in),
        .unsigned_in       (unsigned_in),
        .WB_control_in     (WB_control_in),
        .alu_result_in     (alu_result_in),
        .store_data_in     (store_data_in),
        .rw_in             (rw_in),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_be            (mem_be),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .WB_control_out    (WB_control_out),
        .data_from_mem_out (data_from_mem_out),
        .data_from_ALU_out (data_from_ALU_out),
        .rw_out            (rw_out),
        .valid_out         (valid_out),
        .stall_out         (stall_out),
        .misalign_out      (misalign_out),
        .bus_err_out       (bus_err_out)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic int numBytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    // Completion the stage must produce for one instruction, from the rules:
    // no-op passes through, misaligned / timed-out accesses clear WB control,
    // loads gather big-endian bytes starting at the offset and extend them.
    function automatic exp_t modelResult(input logic rd, input logic wr,
                                         input logic [1:0] size, input logic uns,
                                         input logic [1:0] wb, input logic [31:0] addr,
                                         input logic [4:0] rw, input logic [31:0] rdata,
                                         input int ack_at);
        exp_t        e;
        int          n;
        int          off;
        logic [31:0] v;
        n      = numBytes(size);
        off    = int'(addr[1:0]);
        e.wb   = wb;
        e.alu  = addr;
        e.mem  = 32'h0;
        e.rw   = rw;
        e.mis  = 1'b0;
        e.berr = 1'b0;
        if (!(rd || wr)) return e;
        if ((off % n) != 0) begin
            e.wb  = 2'b00;
            e.mis = 1'b1;
            return e;
        end
        if (ack_at < 1 || ack_at > TIMEOUT) begin
            e.wb   = 2'b00;
            e.berr = 1'b1;
            return e;
        end
        if (wr) return e;
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = (v << 8) | ((rdata >> (8 * (3 - (off + i)))) & 32'hFF);
        if (!uns && n < 4 && v[8*n-1])
            v = v | ~((32'h1 << (8 * n)) - 32'h1);
        e.mem = v;
        return e;
    endfunction

    // Request the bus must carry while an aligned access is outstanding.
    task automatic modelRequest(input logic rd, input logic wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] sdata);
        int          n;
        int          off;
        int          be;
        logic [31:0] mask;
        logic [31:0] w;
        n    = numBytes(size);
        off  = int'(addr[1:0]);
        be   = 0;
        w    = 32'h0;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        for (int i = 0; i < n; i++) be = be | (8 >> (off + i));
        for (int j = 0; j < 4 / n; j++) w = w | ((sdata & mask) << (8 * n * j));
        exp_req_on = (rd || wr) && ((off % n) == 0);
        exp_addr   = addr & 32'hFFFF_FFFC;
        exp_be     = 4'(be);
        exp_we     = wr;
        exp_wdata  = w;
    endtask

    // Drives one instruction for a single cycle, then follows it until
    // valid_out, measuring latency, stall cycles and request cycles.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size,
                                 input logic uns, input logic [1:0] wb,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [4:0] rw, input logic [31:0] rdata,
                                 input int ack_at, input string name);
        exp_t e;
        int   exp_cycles;
        int   exp_lat;
        @(negedge clk);
        mem_read      = rd;
        mem_write     = wr;
        size_in       = size;
        unsigned_in   = uns;
        WB_control_in = wb;
        alu_result_in = addr;
        store_data_in = sdata;
        rw_in         = rw;
        mem_rdata     = rdata;
        resp_ack_at   = ack_at;
        valid_in      = 1'b1;
        e = modelResult(rd, wr, size, uns, wb, addr, rw, rdata, ack_at);
        exp_q.push_back(e);
        modelRequest(rd, wr, size, addr, sdata);

        if (!exp_req_on)                         exp_cycles = 0;
        else if (ack_at < 1 || ack_at > TIMEOUT) exp_cycles = TIMEOUT;
        else                                     exp_cycles = ack_at;
        exp_lat = exp_cycles + 1;

        obs_lat   = -1;
        obs_stall = 0;
        obs_req   = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (stall_out) obs_stall++;
            if (mem_req) begin
                obs_req++;
                obs_be    = mem_be;
                obs_wdata = mem_wdata;
                obs_we    = mem_we;
            end
            if (c > 0 && valid_out) begin
                obs_lat = c;
                break;
            end
            @(negedge clk);
            valid_in = 1'b0;
        end
        valid_in = 1'b0;
        checkOutput({name, "_latency"}, 32'(obs_lat), 32'(exp_lat));
        checkOutput({name, "_stall_cycles"}, 32'(obs_stall), 32'(exp_cycles));
        checkOutput({name, "_req_cycles"}, 32'(obs_req), 32'(exp_cycles));
    endtask

    // Memory responder: acks in the resp_ack_at-th cycle of a request
    // (0 = never). While no request is open it drives idle_ack.
    initial begin
        int rcnt;
        rcnt    = 0;
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                rcnt++;
                mem_ack = (rcnt == resp_ack_at);
            end else begin
                rcnt    = 0;
                mem_ack = idle_ack;
            end
        end
    end

    // Compare process: every completion against the model queue, every
    // request cycle against the modelled bus, and idle error flags.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (valid_out) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("valid_out_unexpected", 32'(valid_out), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("WB_control_out", 32'(WB_control_out), 32'(e.wb));
                        checkOutput("data_from_ALU_out", data_from_ALU_out, e.alu);
                        checkOutput("data_from_mem_out", data_from_mem_out, e.mem);
                        checkOutput("rw_out", 32'(rw_out), 32'(e.rw));
                        checkOutput("misalign_out", 32'(misalign_out), 32'(e.mis));
                        checkOutput("bus_err_out", 32'(bus_err_out), 32'(e.berr));
                    end
                end else begin
                    checkOutput("flags_without_valid", 32'({misalign_out, bus_err_out}), 32'h0);
                end
                if (mem_req) begin
                    if (!exp_req_on) begin
                        checkOutput("mem_req_unexpected", 32'(mem_req), 32'h0);
                    end else begin
                        checkOutput("mem_addr", mem_addr, exp_addr);
                        checkOutput("mem_be", 32'(mem_be), 32'(exp_be));
                        checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
                        if (exp_we) checkOutput("mem_wdata", mem_wdata, exp_wdata);
                    end
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        reset         = 1'b1;
        valid_in      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        size_in       = 2'b00;
        unsigned_in   = 1'b0;
        WB_control_in = 2'b00;
        alu_result_in = 32'h0;
        store_data_in = 32'h0;
        rw_in         = 5'd0;
        mem_rdata     = 32'h0;
        resp_ack_at   = 0;
        idle_ack      = 1'b0;
        exp_req_on    = 1'b0;
        exp_addr      = 32'h0;
        exp_be        = 4'h0;
        exp_we        = 1'b0;
        exp_wdata     = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_valid_out", 32'(valid_out), 32'h0);
        checkOutput("reset_mem_req", 32'(mem_req), 32'h0);
        checkOutput("reset_mem_be", 32'(mem_be), 32'h0);
        checkOutput("reset_data_from_ALU_out", data_from_ALU_out, 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;

        // No-op with a stray ack while idle: must pass straight through.
        idle_ack = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 2'b10, 32'h0000_0010, 32'h0, 5'd5, 32'h0, 0, "noop");
        idle_ack = 1'b0;
        checkOutput("noop_alu_literal", data_from_ALU_out, 32'h0000_0010);

        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 32'h0000_0103, 32'h0, 5'd7, 32'h1122_33F4, 3, "ld_byte_s");
        checkOutput("ld_byte_s_be_literal", 32'(obs_be), 32'h1);
        checkOutput("ld_byte_s_data_literal", data_from_mem_out, 32'hFFFF_FFF4);

        applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 2'b01, 32'h0000_0102, 32'h0, 5'd8, 32'hAAAA_8001, 1, "ld_half_u");
        checkOutput("ld_half_u_be_literal", 32'(obs_be), 32'h3);
        checkOutput("ld_half_u_data_literal", data_from_mem_out, 32'h0000_8001);

        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 2'b01, 32'h0000_0200, 32'h0, 5'd9, 32'h8001_AAAA, 2, "ld_half_s");
        checkOutput("ld_half_s_be_literal", 32'(obs_be), 32'hC);
        checkOutput("ld_half_s_data_literal", data_from_mem_out, 32'hFFFF_8001);

        applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 2'b01, 32'h0000_0300, 32'h0, 5'd10, 32'hDEAD_BEEF, 1, "ld_word");
        checkOutput("ld_word_data_literal", data_from_mem_out, 32'hDEAD_BEEF);

        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 32'h0000_0400, 32'h0, 5'd11, 32'h80FF_FFFF, 2, "ld_byte_u");
        checkOutput("ld_byte_u_data_literal", data_from_mem_out, 32'h0000_0080);

        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'h0000_0101, 32'h0000_00AB, 5'd0, 32'h0, 1, "st_byte");
        checkOutput("st_byte_we_literal", 32'(obs_we), 32'h1);
        checkOutput("st_byte_be_literal", 32'(obs_be), 32'h4);
        checkOutput("st_byte_wdata_literal", obs_wdata, 32'hABAB_ABAB);

        // Read and write together resolve as a store.
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 32'h0000_0106, 32'h1234_CAFE, 5'd0, 32'h5555_5555, 2, "st_half");
        checkOutput("st_half_wdata_literal", obs_wdata, 32'hCAFE_CAFE);
        checkOutput("st_half_mem_literal", data_from_mem_out, 32'h0);

        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 2'b11, 32'h0000_0002, 32'h0, 5'd12, 32'h0, 1, "mis_word");
        checkOutput("mis_word_flag_literal", 32'(misalign_out), 32'h1);
        checkOutput("mis_word_wb_literal", 32'(WB_control_out), 32'h0);

        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 32'h0000_0105, 32'h0, 5'd13, 32'h0, 1, "mis_half");

        // Ack in the last allowed cycle beats the timeout.
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 2'b01, 32'h0000_0600, 32'h0, 5'd14, 32'h0BAD_F00D, TIMEOUT, "ack_at_limit");
        checkOutput("ack_at_limit_data_literal", data_from_mem_out, 32'h0BAD_F00D);

        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 2'b01, 32'h0000_0700, 32'h0, 5'd15, 32'h0, 0, "timeout");
        checkOutput("timeout_berr_literal", 32'(bus_err_out), 32'h1);
        checkOutput("timeout_lat_literal", 32'(obs_lat), 32'd16);

        // Reset in the middle of an access discards it.
        @(negedge clk);
        mem_read      = 1'b1;
        mem_write     = 1'b0;
        size_in       = 2'b10;
        WB_control_in = 2'b01;
        alu_result_in = 32'h0000_0800;
        rw_in         = 5'd16;
        resp_ack_at   = 0;
        valid_in      = 1'b1;
        modelRequest(1'b1, 1'b0, 2'b10, 32'h0000_0800, 32'h0);
        @(negedge clk);
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("pre_reset_mem_req", 32'(mem_req), 32'h1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        exp_req_on = 1'b0;
        #1;
        checkOutput("mid_reset_mem_req", 32'(mem_req), 32'h0);
        checkOutput("mid_reset_stall", 32'(stall_out), 32'h0);
        checkOutput("mid_reset_alu", data_from_ALU_out, 32'h0);
        checkOutput("mid_reset_mem_data", data_from_mem_out, 32'h0);
        checkOutput("mid_reset_wb_rw", 32'({WB_control_out, rw_out}), 32'h0);
        checkOutput("mid_reset_addr", mem_addr, 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;

        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 32'h0000_0077, 32'h0, 5'd17, 32'h0, 0, "after_reset");
        checkOutput("after_reset_alu_literal", data_from_ALU_out, 32'h0000_0077);

        repeat (3) @(negedge clk);
        #2;
        checkOutput("leftover_expectations", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
